// File: rtl/trailing_zero_bits_insert.sv
// Shifts an operand left by a clamped count, one bit per cycle, with a
// valid/ready handshake on both sides and a sticky flag for shifted-out ones.
module trailing_zero_bits_insert #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [WIDTH-1:0]       operand_i,
    input  logic [$clog2(WIDTH):0] count_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [31:0]            result_o,
    output logic                   lost_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] WidthC = CW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic             lost_q, lost_d;
    logic [CW-1:0]    eff_count;
    logic             accept;

    assign eff_count = (count_i > WidthC) ? WidthC : count_i;
    assign accept    = valid_i & ready_o & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            remaining_q <= '0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            lost_q      <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = (eff_count == '0) ? StDone : StShift;
                StShift: if (remaining_q == CW'(1)) state_d = StDone;
                StDone:  if (ready_i) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        lost_d      = lost_q;
        if (clear_i) begin
            shreg_d     = '0;
            remaining_d = '0;
            lost_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shreg_d     = operand_i;
                        remaining_d = eff_count;
                        lost_d      = 1'b0;
                    end
                end
                StShift: begin
                    shreg_d     = shreg_q << 1;
                    lost_d      = lost_q | shreg_q[WIDTH-1];
                    remaining_d = remaining_q - CW'(1);
                end
                StDone: begin
                    // Drop the finished result once it has been handed off.
                    if (ready_i) begin
                        shreg_d     = '0;
                        remaining_d = '0;
                        lost_d      = 1'b0;
                    end
                end
                default: begin
                    shreg_d     = '0;
                    remaining_d = '0;
                    lost_d      = 1'b0;
                end
            endcase
        end
    end

    // Outputs are gated by state so they read zero outside DONE.
    always_comb begin
        ready_o  = (state_q == StIdle) & rst_ni;
        valid_o  = (state_q == StDone);
        result_o = valid_o ? 32'(shreg_q) : 32'h0;
        lost_o   = valid_o & lost_q;
    end

endmodule

// File: tb/tb_trailing_zero_bits_insert.sv
// Randomized bench for trailing_zero_bits_insert, checked against an
// arithmetic reference model of the shift, clamp, lost flag and latency.
module tb_trailing_zero_bits_insert;

    localparam int unsigned WIDTH = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   clear_i = 1'b0;
    logic                   valid_i = 1'b0;
    logic                   ready_o;
    logic [WIDTH-1:0]       operand_i = '0;
    logic [$clog2(WIDTH):0] count_i = '0;
    logic                   valid_o;
    logic                   ready_i = 1'b0;
    logic [31:0]            result_o;
    logic                   lost_o;

    int n_checks = 0;
    int n_errors = 0;

    trailing_zero_bits_insert #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .operand_i (operand_i),
        .count_i   (count_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .lost_o    (lost_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tz32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 32;
    endfunction

    // Reference model: plain wide shift, then split into kept and lost parts.
    task automatic model(input logic [WIDTH-1:0] op, input int cnt, output int eff,
                         output logic [31:0] res, output logic lost);
        logic [63:0] full;
        eff  = (cnt > WIDTH) ? WIDTH : cnt;
        full = 64'(op) << eff;
        res  = 32'(full[WIDTH-1:0]);
        lost = |full[63:WIDTH];
    endtask

    // One full transaction; ready_i held low for 'hold' cycles in DONE.
    task automatic run_txn(input logic [WIDTH-1:0] op, input int cnt, input int hold);
        int          eff, lat;
        logic [31:0] exp_res;
        logic        exp_lost;
        logic        shift_zero;
        model(op, cnt, eff, exp_res, exp_lost);
        check("ready_idle", 64'(ready_o), 64'd1);
        valid_i   = 1'b1;
        operand_i = op;
        count_i   = cnt[$clog2(WIDTH):0];
        ready_i   = 1'b0;
        @(negedge clk_i);
        valid_i    = 1'b0;
        lat        = 1;
        shift_zero = 1'b1;
        while (!valid_o && lat < 40) begin
            if (result_o != 0 || lost_o || ready_o) shift_zero = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        check("latency", 64'(lat), 64'(eff + 1));
        check("shift_outputs_zero", 64'(shift_zero), 64'd1);
        check("result", 64'(result_o), 64'(exp_res));
        check("lost", 64'(lost_o), 64'(exp_lost));
        check("ready_done", 64'(ready_o), 64'd0);
        if (op != 0 && !exp_lost)
            check("roundtrip_tz", 64'(tz32(result_o)), 64'(tz32(32'(op)) + eff));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                valid_i   = 1'b1;
                operand_i = WIDTH'($urandom);
                count_i   = '0;
                @(negedge clk_i);
            end
            valid_i = 1'b0;
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_result", 64'(result_o), 64'(exp_res));
            check("hold_lost", 64'(lost_o), 64'(exp_lost));
            check("hold_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("post_valid", 64'(valid_o), 64'd0);
        check("post_result", 64'(result_o), 64'd0);
    endtask

    initial begin
        logic never_valid;
        #1;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_lost", 64'(lost_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("ready_after_rst", 64'(ready_o), 64'd1);
        @(negedge clk_i);

        run_txn(16'h0001, 4, 0);
        run_txn(16'h8001, 1, 0);
        run_txn(16'hABCD, 0, 0);
        run_txn(16'hFFFF, 20, 0);
        run_txn(16'h0000, 7, 0);
        run_txn(16'h1234, 3, 10);

        // Abort mid-SHIFT with a competing request in the same cycle.
        valid_i   = 1'b1;
        operand_i = 16'h00F0;
        count_i   = 5'd10;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        clear_i = 1'b1;
        valid_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("clear_idle", 64'(ready_o), 64'd1);
        never_valid = 1'b1;
        repeat (20) begin
            if (valid_o) never_valid = 1'b0;
            @(negedge clk_i);
        end
        check("clear_no_valid", 64'(never_valid), 64'd1);

        // Reset asserted mid-SHIFT drops the transaction immediately.
        valid_i   = 1'b1;
        operand_i = 16'h0003;
        count_i   = 5'd12;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_result", 64'(result_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("midrst_release_ready", 64'(ready_o), 64'd1);
        never_valid = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (valid_o) never_valid = 1'b0;
        end
        check("midrst_no_valid", 64'(never_valid), 64'd1);

        for (int k = 0; k < 40; k++) begin
            logic [WIDTH-1:0] op;
            op = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            run_txn(op, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
